// File: rtl/udma_uart_cfg_seq.sv
// Sequences queued write/read/poll commands onto the uDMA UART cfg bus, one response per command.
// Optional poll timeout counter: define UART_CFG_SEQ_TIMEOUT_EN.
module udma_uart_cfg_seq #(
  parameter int CMD_DEPTH = 4,
  parameter int POLL_GAP  = 8,
  parameter int POLL_MAX  = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [31:0] cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] cfg_data_o,
  output logic [4:0]  cfg_addr_o,
  output logic        cfg_valid_o,
  output logic        cfg_rwn_o,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_ready_i,
  output logic [1:0]  dbg_state_o
);

  // Valid/ready: a transfer happens in a cycle where valid and ready are both high at the
  // rising clock edge; valid holds its payload stable until that cycle.

  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);
  localparam logic [7:0]  GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam logic [1:0]  OP_WR   = 2'b00;
  localparam logic [1:0]  OP_POLL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_RESP} state_t;

  state_t state_q, state_d;

  logic [1:0]  f_op   [CMD_DEPTH];
  logic [4:0]  f_addr [CMD_DEPTH];
  logic [31:0] f_data [CMD_DEPTH];
  logic [31:0] f_mask [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic push, pop;

  logic [1:0]  cur_op_q;
  logic [4:0]  cur_addr_q;
  logic [31:0] cur_data_q, cur_mask_q;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d, load_rsp;
  logic [7:0]  gap_cnt_q;
  logic        timeout_hit;

  assign cmd_ready_o = (count_q != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;

  // Storage needs no reset: emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      f_op[wr_ptr_q]   <= cmd_op_i;
      f_addr[wr_ptr_q] <= cmd_addr_i;
      f_data[wr_ptr_q] <= cmd_data_i;
      f_mask[wr_ptr_q] <= cmd_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef UART_CFG_SEQ_TIMEOUT_EN
  logic [15:0] rd_cnt_q, rd_cnt_inc;
  assign rd_cnt_inc  = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
  assign timeout_hit = (rd_cnt_inc >= 16'(POLL_MAX));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_cnt_q <= '0;
    end else if (pop) begin
      rd_cnt_q <= '0;
    end else if (state_q == S_ISSUE && cfg_ready_i && cur_op_q == OP_POLL) begin
      rd_cnt_q <= rd_cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_rsp   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = cfg_data_i;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cfg_ready_i) begin
          if (cur_op_q == OP_POLL) begin
            if ((cfg_data_i & cur_mask_q) == (cur_data_q & cur_mask_q)) begin
              load_rsp = 1'b1;
            end else if (timeout_hit) begin
              load_rsp  = 1'b1;
              rsp_err_d = 1'b1;
            end else if (POLL_GAP != 0) begin
              state_d = S_GAP;
            end
          end else begin
            load_rsp   = 1'b1;
            rsp_data_d = (cur_op_q == OP_WR) ? 32'h0 : cfg_data_i;
          end
          if (load_rsp) state_d = S_RESP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cur_op_q   <= 2'b01;
      cur_addr_q <= '0;
      cur_data_q <= '0;
      cur_mask_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= (state_q == S_GAP) ? gap_cnt_q + 8'd1 : 8'd0;
      if (pop) begin
        cur_op_q   <= f_op[rd_ptr_q];
        cur_addr_q <= f_addr[rd_ptr_q];
        cur_data_q <= f_data[rd_ptr_q];
        cur_mask_q <= f_mask[rd_ptr_q];
      end
      if (load_rsp) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  // Reserved op 11 falls out as a read because only 00 drives a write.
  assign cfg_valid_o = (state_q == S_ISSUE);
  assign cfg_rwn_o   = (cur_op_q != OP_WR);
  assign cfg_addr_o  = cur_addr_q;
  assign cfg_data_o  = cur_data_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule
